// File: rtl/ram_rr_arbiter.sv
// rtl/ram_rr_arbiter.sv - two-port round-robin arbiter/sequencer for a single-port RAM
//
// Serialises accesses from two requesters onto one RAM port. Each grant takes
// three cycles: IDLE (arbitrate and latch), ACCESS (one strobe cycle) and RESP
// (one-cycle ack with read data). All outputs are registered.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req0/1, we0/1                request (held until ack), 1 = write / 0 = read
//   addr0/1, wdata0/1            access address and write data
//   ack0/1                       one-cycle completion pulse
//   rdata0/1                     read data, updated only on a read ack to that port
//   ram_addr, ram_datain         RAM address and write data
//   ram_read, ram_write          RAM strobes, high for exactly one cycle per access
//   ram_dataout                  RAM read data (combinational from ram_addr)

module ram_rr_arbiter #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_datain,
    output logic          ram_read,
    output logic          ram_write,
    input  logic [DW-1:0] ram_dataout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q;
    logic          ptr_q;       // port holding priority on a tie
    logic          id_q;        // port currently being served
    logic          ack0_q;
    logic          ack1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_datain_q;
    logic          ram_read_q;
    logic          ram_write_q;

    // Winner selection: a lone requester wins outright, a tie goes to ptr_q.
    logic          grant1_d;
    logic          grant_we_d;
    logic [AW-1:0] grant_addr_d;
    logic [DW-1:0] grant_wdata_d;

    always_comb begin
        grant1_d      = req1 && (!req0 || ptr_q);
        grant_we_d    = grant1_d ? we1    : we0;
        grant_addr_d  = grant1_d ? addr1  : addr0;
        grant_wdata_d = grant1_d ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            id_q         <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ram_addr_q   <= '0;
            ram_datain_q <= '0;
            ram_read_q   <= 1'b0;
            ram_write_q  <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses unless set below.
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        // Latching straight into the RAM-facing registers makes
                        // the strobe appear in the ACCESS cycle and freezes the
                        // request against later changes on the inputs.
                        id_q       <= grant1_d;
                        ram_addr_q <= grant_addr_d;
                        if (grant_we_d) begin
                            ram_datain_q <= grant_wdata_d;
                            ram_write_q  <= 1'b1;
                        end else begin
                            ram_read_q   <= 1'b1;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // ram_read_q is still high here exactly for a read access.
                    if (id_q) begin
                        ack1_q <= 1'b1;
                        if (ram_read_q) rdata1_q <= ram_dataout;
                    end else begin
                        ack0_q <= 1'b1;
                        if (ram_read_q) rdata0_q <= ram_dataout;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    ptr_q   <= ~id_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign ram_addr   = ram_addr_q;
    assign ram_datain = ram_datain_q;
    assign ram_read   = ram_read_q;
    assign ram_write  = ram_write_q;

endmodule
